// File: rtl/i2c_target_pkg.sv
// i2c_target_pkg: state encoding, default address and ACK/NACK levels shared by the I2C target and master
package i2c_target_pkg;
  localparam logic [6:0] DEFAULT_ADDR = 7'h58;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK
  } state_t;
  function automatic logic [7:0] addr_byte(input logic [6:0] a, input logic rw);
    return {a, rw};
  endfunction
endpackage

// File: rtl/i2c_target_line_sync.sv
// i2c_target_line_sync: SCL/SDA synchronizer with SCL edge and START/STOP detection
// Ports: clk, rst_n (async active-low); scl_i/sda_i raw bus lines; sda_o synced SDA level;
//        scl_rise_o/scl_fall_o SCL edges; start_o/stop_o bus conditions (all single-cycle)
module i2c_target_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_prev_q, sda_prev_q, scl;
  // Idle bus is high, so reset to 1 to avoid a spurious edge when reset lifts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl;
      sda_prev_q <= sda_o;
    end
  end
  assign scl = scl_sync_q[SYNC_STAGES-1];
  assign sda_o = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise_o = scl & ~scl_prev_q;
  assign scl_fall_o = ~scl & scl_prev_q;
  // SCL must be high on both samples so an SDA edge coinciding with an SCL edge is not a condition
  assign start_o = scl & scl_prev_q & sda_prev_q & ~sda_o;
  assign stop_o = scl & scl_prev_q & ~sda_prev_q & sda_o;
endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C target with pointer-based byte register port, open-drain SDA enable
// Ports: clk, rst_n (async active-low); scl_i/sda_i bus inputs; sda_oe_o pull SDA low;
//        wr_valid_o/wr_addr_o/wr_data_o write strobe; rd_addr_o/rd_data_i combinational read; busy_o
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = DEFAULT_ADDR,
  parameter int SYNC_STAGES = 2,
  parameter int PTR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe_o,
  output logic             wr_valid_o,
  output logic [PTR_W-1:0] wr_addr_o,
  output logic [7:0]       wr_data_o,
  output logic [PTR_W-1:0] rd_addr_o,
  input  logic [7:0]       rd_data_i,
  output logic             busy_o
);
  logic sda, scl_rise, scl_fall, start, stop;
  i2c_target_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst_n(rst_n), .scl_i(scl_i), .sda_i(sda_i), .sda_o(sda),
    .scl_rise_o(scl_rise), .scl_fall_o(scl_fall), .start_o(start), .stop_o(stop)
  );
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, wr_data_q, wr_data_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d;
  logic sda_oe_q, sda_oe_d, busy_q, busy_d, wr_valid_q, wr_valid_d;
  logic byte_done, addr_match;
  assign byte_done = cnt_q == 4'd8;
  assign addr_match = shift_q[7:1] == TARGET_ADDR;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      shift_q <= '0;
      ptr_q <= '0;
      sda_oe_q <= 1'b0;
      busy_q <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      shift_q <= shift_d;
      ptr_q <= ptr_d;
      sda_oe_q <= sda_oe_d;
      busy_q <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (stop) state_d = IDLE;
    else if (start) state_d = ADDR;
    else case (state_q)
      ADDR:       state_d = scl_fall && byte_done ? (addr_match ? ADDR_ACK : IDLE) : state_q;
      // shift_q still holds the address byte here, so bit 0 is the R/W flag
      ADDR_ACK:   state_d = scl_fall ? (shift_q[0] ? RDATA : PTR) : state_q;
      PTR:        state_d = scl_fall && byte_done ? PTR_ACK : state_q;
      PTR_ACK:    state_d = scl_fall ? WDATA : state_q;
      WDATA:      state_d = scl_fall && byte_done ? WDATA_ACK : state_q;
      WDATA_ACK:  state_d = scl_fall ? WDATA : state_q;
      RDATA:      state_d = scl_fall && byte_done ? RDATA_MACK : state_q;
      RDATA_MACK: state_d = scl_rise && sda == NACK ? IDLE : scl_fall ? RDATA : state_q;
      default:    state_d = state_q;
    endcase
  end
  always_comb begin
    cnt_d = cnt_q;
    shift_d = shift_q;
    ptr_d = ptr_q;
    sda_oe_d = sda_oe_q;
    busy_d = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (stop) begin
      sda_oe_d = 1'b0;
      busy_d = 1'b0;
    end else if (start) begin
      sda_oe_d = 1'b0;
      cnt_d = '0;
    end else case (state_q)
      ADDR, PTR, WDATA: begin
        if (scl_rise) begin
          shift_d = {shift_q[6:0], sda};
          cnt_d = cnt_q + 4'd1;
        end
        if (scl_fall && byte_done) begin
          cnt_d = '0;
          sda_oe_d = state_q != ADDR || addr_match;
          busy_d = state_q == ADDR ? addr_match : busy_q;
          if (state_q == PTR) ptr_d = PTR_W'(shift_q);
          if (state_q == WDATA) begin
            wr_valid_d = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = shift_q;
            ptr_d = ptr_q + PTR_W'(1);
          end
        end
      end
      ADDR_ACK, PTR_ACK, WDATA_ACK: begin
        if (scl_fall) begin
          cnt_d = '0;
          sda_oe_d = state_q == ADDR_ACK && shift_q[0] ? ~rd_data_i[7] : 1'b0;
          if (state_q == ADDR_ACK && shift_q[0]) shift_d = rd_data_i;
        end
      end
      RDATA: begin
        if (scl_rise) cnt_d = cnt_q + 4'd1;
        // after the 8th bit let go of SDA so the master can ACK/NACK
        if (scl_fall) begin
          sda_oe_d = byte_done ? 1'b0 : ~shift_q[6];
          if (!byte_done) shift_d = {shift_q[6:0], 1'b0};
        end
      end
      RDATA_MACK: begin
        // pointer advances on the ACK so rd_data_i has the next byte ready by the following fall
        if (scl_rise) begin
          busy_d = sda == NACK ? 1'b0 : busy_q;
          ptr_d = sda == ACK ? ptr_q + PTR_W'(1) : ptr_q;
        end
        if (scl_fall) begin
          cnt_d = '0;
          shift_d = rd_data_i;
          sda_oe_d = ~rd_data_i[7];
        end
      end
      default: ;
    endcase
  end
  assign sda_oe_o = sda_oe_q;
  assign busy_o = busy_q;
  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign rd_addr_o = ptr_q;
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed bus-level checks of i2c_target through an open-drain master model
module tb_i2c_target;
  import i2c_target_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
  logic sda_oe, wr_valid, busy, sda_bus;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  logic [7:0] mem [256];
  logic [15:0] wlog[$];
  int oe_cnt = 0, busy_cnt = 0, n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  assign sda_bus = sda_m & ~sda_oe;
  assign rd_data = mem[rd_addr];
  i2c_target dut (
    .clk(clk), .rst_n(rst_n), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe_o(sda_oe),
    .wr_valid_o(wr_valid), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .rd_addr_o(rd_addr), .rd_data_i(rd_data), .busy_o(busy)
  );
  always @(negedge clk) begin
    if (wr_valid) wlog.push_back({wr_addr, wr_data});
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask
  task automatic hold();
    repeat (10) @(posedge clk);
    #1;
  endtask
  task automatic i2c_start();
    sda_m = 1'b1; hold(); scl_m = 1'b1; hold(); sda_m = 1'b0; hold(); scl_m = 1'b0; hold();
  endtask
  task automatic i2c_stop();
    sda_m = 1'b0; hold(); scl_m = 1'b1; hold(); sda_m = 1'b1; hold();
  endtask
  task automatic put_bit(input logic b);
    sda_m = b; hold(); scl_m = 1'b1; hold(); scl_m = 1'b0; hold();
  endtask
  task automatic wr_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    sda_m = 1'b1; hold(); scl_m = 1'b1; hold(); ack = sda_bus; scl_m = 1'b0; hold();
  endtask
  task automatic rd_byte(input logic nack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      hold(); scl_m = 1'b1; hold(); b[i] = sda_bus; scl_m = 1'b0;
    end
    sda_m = nack; hold(); scl_m = 1'b1; hold(); scl_m = 1'b0; hold(); sda_m = 1'b1;
  endtask
  task automatic t1(input string p);
    logic a0, a1, a2;
    int w0;
    w0 = wlog.size();
    i2c_start();
    wr_byte(8'hB0, a0);
    chk({p, " busy after addr"}, busy, 1);
    wr_byte(8'h30, a1);
    wr_byte(8'h01, a2);
    i2c_stop();
    hold();
    chk({p, " acks"}, {a0, a1, a2}, 0);
    chk({p, " write count"}, wlog.size() - w0, 1);
    chk({p, " write addr/data"}, wlog.size() > w0 ? wlog[w0] : 16'hxxxx, 16'h3001);
    chk({p, " busy after stop"}, busy, 0);
  endtask
  initial begin
    logic a0, a1, a2, a3, a4;
    logic [7:0] r0, r1, r2, ab;
    int w0, o0, b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h36] = 8'h11; mem[8'h37] = 8'h22; mem[8'h38] = 8'h33;
    hold();
    chk("reset sda_oe", sda_oe, 0);
    chk("reset wr_valid", wr_valid, 0);
    chk("reset wr_addr", wr_addr, 0);
    chk("reset wr_data", wr_data, 0);
    chk("reset pointer", rd_addr, 0);
    chk("reset busy", busy, 0);
    rst_n = 1'b1;
    hold();
    t1("t1");
    w0 = wlog.size();
    i2c_start();
    wr_byte(8'hB0, a0); wr_byte(8'hFE, a1); wr_byte(8'hAA, a2); wr_byte(8'hBB, a3); wr_byte(8'hCC, a4);
    i2c_stop();
    hold();
    chk("t2 acks", {a0, a1, a2, a3, a4}, 0);
    chk("t2 write count", wlog.size() - w0, 3);
    chk("t2 write 0", wlog.size() > w0 ? wlog[w0] : 16'hxxxx, 16'hFEAA);
    chk("t2 write 1", wlog.size() > w0 + 1 ? wlog[w0+1] : 16'hxxxx, 16'hFFBB);
    chk("t2 write 2 wrap", wlog.size() > w0 + 2 ? wlog[w0+2] : 16'hxxxx, 16'h00CC);
    chk("t2 pointer", rd_addr, 8'h01);
    w0 = wlog.size(); o0 = oe_cnt; b0 = busy_cnt;
    ab = addr_byte(7'h21, 1'b0);
    i2c_start();
    wr_byte(ab, a0); wr_byte(8'h30, a1);
    i2c_stop();
    hold();
    chk("t3 addr nack", a0, 1);
    chk("t3 sda_oe never", oe_cnt - o0, 0);
    chk("t3 no write", wlog.size() - w0, 0);
    chk("t3 busy never", busy_cnt - b0, 0);
    i2c_start();
    wr_byte(8'hB0, a0); wr_byte(8'h36, a1);
    i2c_start();
    wr_byte(8'hB1, a2);
    chk("t4 acks", {a0, a1, a2}, 0);
    rd_byte(1'b0, r0); rd_byte(1'b0, r1); rd_byte(1'b1, r2);
    chk("t4 byte 0", r0, 8'h11);
    chk("t4 byte 1", r1, 8'h22);
    chk("t4 byte 2", r2, 8'h33);
    chk("t4 sda released", sda_oe, 0);
    chk("t4 busy after nack", busy, 0);
    chk("t4 pointer", rd_addr, 8'h38);
    i2c_stop();
    hold();
    w0 = wlog.size();
    i2c_start();
    wr_byte(8'hB0, a0); wr_byte(8'h10, a1);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
    i2c_start();
    wr_byte(8'hB0, a2); wr_byte(8'h20, a3); wr_byte(8'h55, a4);
    i2c_stop();
    hold();
    chk("t5 acks", {a0, a1, a2, a3, a4}, 0);
    chk("t5 write count", wlog.size() - w0, 1);
    chk("t5 write addr/data", wlog.size() > w0 ? wlog[w0] : 16'hxxxx, 16'h2055);
    ab = 8'hB0;
    i2c_start();
    for (int i = 7; i >= 0; i--) put_bit(ab[i]);
    sda_m = 1'b1;
    hold();
    chk("t6 ack driven", sda_oe, 1);
    chk("t6 busy before reset", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6 async sda_oe", sda_oe, 0);
    chk("t6 async busy", busy, 0);
    chk("t6 async pointer", rd_addr, 0);
    scl_m = 1'b1;
    hold();
    rst_n = 1'b1;
    hold();
    t1("t6 rerun");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
